wb_burst_dma: RTL

- Wishbone initiator that copies a block of 32-bit words from a source word address to a destination word address.
- Sits as an additional master port on the system Wishbone arbiter, beside the CPU instruction and data buses, and targets the SRAM slave.
- Transfers in chunks: an incrementing read burst fills an internal buffer, then an incrementing write burst drains it.
- Must tolerate arbitrary slave ack latency, including randomly stalled acks.

---
 rtl/wb_burst_dma_if.sv | 28 ++
 rtl/wb_burst_dma.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_dma_if.sv
// Purpose: Wishbone B4 pipelined-less burst bus bundle between the DMA initiator and the SRAM/arbiter side.
// Latency: none; plain wires only.
// Backpressure: the slave stalls a beat by holding wb_ack_i low; the master holds every request signal until ack or err.
// Ports (master view): wb_adr_o, wb_dat_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, wb_bte_o out;
//                      wb_dat_i, wb_ack_i, wb_err_i in.
interface wb_burst_dma_if;
    logic [29:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic        wb_ack_i;
    logic        wb_err_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, wb_bte_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, wb_bte_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/wb_burst_dma.sv
// Purpose: Wishbone block-copy initiator; read burst fills a BURST_LEN buffer, write burst drains it, chunk by chunk.
// Latency: first read beat is on the bus the cycle after an accepted start; done pulses the cycle after the final write ack.
// Backpressure: every bus output is registered and held while wb_ack_i=0; wb_err_i aborts the whole transfer.
//
// Ports: sys_clk/sys_rst_n (async active-low); start/src_adr/dst_adr/length request (sampled when idle);
//        busy/done/error status; wb (master modport of wb_burst_dma_if) carries the Wishbone bus.
// Optional: define WB_BURST_DMA_FILL_EN to add fill_mode/fill_data, which turn a copy into a constant fill
//           of the destination (write bursts only, source ignored).
module wb_burst_dma #(
    parameter int BURST_LEN = 4,
    parameter int LEN_W     = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic [29:0]       src_adr,
    input  logic [29:0]       dst_adr,
    input  logic [LEN_W-1:0]  length,
`ifdef WB_BURST_DMA_FILL_EN
    input  logic              fill_mode,
    input  logic [31:0]       fill_data,
`endif
    output logic              busy,
    output logic              done,
    output logic              error,
    wb_burst_dma_if.master    wb
);

    localparam int IDX_W = $clog2(BURST_LEN);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_END  = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_GAP,
        ST_WR,
        ST_FIN
    } state_t;

    state_t            state_q;
    logic [29:0]       src_q;
    logic [29:0]       dst_q;
    logic [LEN_W-1:0]  len_q;        // words still to move, excluding the chunk in flight
    logic [CNT_W-1:0]  chunk_q;      // beats in the current chunk
    logic [CNT_W-1:0]  beat_q;       // beat index inside the current burst
    logic              gap_to_wr_q;  // GAP leads into the write half of the chunk
    logic              fill_q;
    logic [31:0]       fill_dat_q;

    logic              cyc_q;
    logic              stb_q;
    logic              we_q;
    logic [29:0]       adr_q;
    logic [31:0]       dat_q;
    logic [2:0]        cti_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;

    logic [31:0]       buf_q [BURST_LEN];

    // Request-side fill controls collapse to constants when the feature is compiled out.
    logic              start_fill;
    logic [31:0]       start_fill_dat;
`ifdef WB_BURST_DMA_FILL_EN
    assign start_fill     = fill_mode;
    assign start_fill_dat = fill_data;
`else
    assign start_fill     = 1'b0;
    assign start_fill_dat = 32'h0;
`endif

    function automatic logic [CNT_W-1:0] chunk_of(input logic [LEN_W-1:0] l);
        if (l >= LEN_W'(BURST_LEN)) begin
            return CNT_W'(BURST_LEN);
        end
        return l[CNT_W-1:0];
    endfunction

    function automatic logic [2:0] cti_for(input logic last);
        return last ? CTI_END : CTI_INCR;
    endfunction

    logic [CNT_W-1:0]  start_chunk_d;
    logic [CNT_W-1:0]  beat_inc_d;
    logic              last_beat_d;
    logic              inc_is_last_d;
    logic [LEN_W-1:0]  next_len_d;
    logic [CNT_W-1:0]  next_chunk_d;
    logic [29:0]       next_dst_d;

    always_comb begin
        start_chunk_d = chunk_of(length);
        beat_inc_d    = beat_q + CNT_W'(1);
        last_beat_d   = (beat_q == chunk_q - CNT_W'(1));
        inc_is_last_d = (beat_inc_d == chunk_q - CNT_W'(1));
        next_len_d    = len_q - LEN_W'(chunk_q);
        next_chunk_d  = chunk_of(next_len_d);
        next_dst_d    = dst_q + 30'(chunk_q);
    end

    // Read data is captured straight into the chunk buffer; an err beat never writes.
    always_ff @(posedge sys_clk) begin
        if (state_q == ST_RD && wb.wb_ack_i && !wb.wb_err_i) begin
            buf_q[beat_q[IDX_W-1:0]] <= wb.wb_dat_i;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            chunk_q     <= '0;
            beat_q      <= '0;
            gap_to_wr_q <= 1'b0;
            fill_q      <= 1'b0;
            fill_dat_q  <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            cti_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        src_q      <= src_adr;
                        dst_q      <= dst_adr;
                        fill_q     <= start_fill;
                        fill_dat_q <= start_fill_dat;
                        error_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        beat_q     <= '0;
                        chunk_q    <= start_chunk_d;
                        // len_q holds what remains after the chunk now starting.
                        len_q      <= length - LEN_W'(start_chunk_d);
                        if (length == '0) begin
                            // Zero-length request: one quiet busy cycle in GAP, then FIN.
                            gap_to_wr_q <= 1'b0;
                            state_q     <= ST_GAP;
                        end else if (start_fill) begin
                            cyc_q   <= 1'b1;
                            stb_q   <= 1'b1;
                            we_q    <= 1'b1;
                            adr_q   <= dst_adr;
                            dat_q   <= start_fill_dat;
                            cti_q   <= cti_for(start_chunk_d == CNT_W'(1));
                            state_q <= ST_WR;
                        end else begin
                            cyc_q   <= 1'b1;
                            stb_q   <= 1'b1;
                            we_q    <= 1'b0;
                            adr_q   <= src_adr;
                            cti_q   <= cti_for(start_chunk_d == CNT_W'(1));
                            state_q <= ST_RD;
                        end
                    end
                end

                ST_RD: begin
                    if (wb.wb_err_i) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        cti_q   <= '0;
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end else if (wb.wb_ack_i) begin
                        if (last_beat_d) begin
                            cyc_q       <= 1'b0;
                            stb_q       <= 1'b0;
                            cti_q       <= '0;
                            beat_q      <= '0;
                            gap_to_wr_q <= 1'b1;
                            state_q     <= ST_GAP;
                        end else begin
                            beat_q <= beat_inc_d;
                            adr_q  <= adr_q + 30'd1;
                            cti_q  <= cti_for(inc_is_last_d);
                        end
                    end
                end

                ST_GAP: begin
                    if (gap_to_wr_q) begin
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        we_q    <= 1'b1;
                        adr_q   <= dst_q;
                        dat_q   <= buf_q[0];
                        cti_q   <= cti_for(chunk_q == CNT_W'(1));
                        state_q <= ST_WR;
                    end else if (chunk_q == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end else begin
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        we_q    <= 1'b0;
                        adr_q   <= src_q;
                        cti_q   <= cti_for(chunk_q == CNT_W'(1));
                        state_q <= ST_RD;
                    end
                end

                ST_WR: begin
                    if (wb.wb_err_i) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        cti_q   <= '0;
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end else if (wb.wb_ack_i) begin
                        if (last_beat_d) begin
                            // Chunk retired: move both windows on and size the next chunk.
                            src_q   <= src_q + 30'(chunk_q);
                            dst_q   <= next_dst_d;
                            len_q   <= len_q - LEN_W'(chunk_of(len_q));
                            chunk_q <= chunk_of(len_q);
                            beat_q  <= '0;
                            if (len_q == '0) begin
                                cyc_q   <= 1'b0;
                                stb_q   <= 1'b0;
                                we_q    <= 1'b0;
                                cti_q   <= '0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= ST_FIN;
                            end else if (fill_q) begin
                                // Fill has nothing to read, so the next write burst follows directly.
                                adr_q <= next_dst_d;
                                dat_q <= fill_dat_q;
                                cti_q <= cti_for(chunk_of(len_q) == CNT_W'(1));
                            end else begin
                                cyc_q       <= 1'b0;
                                stb_q       <= 1'b0;
                                we_q        <= 1'b0;
                                cti_q       <= '0;
                                gap_to_wr_q <= 1'b0;
                                state_q     <= ST_GAP;
                            end
                        end else begin
                            beat_q <= beat_inc_d;
                            adr_q  <= adr_q + 30'd1;
                            dat_q  <= fill_q ? fill_dat_q : buf_q[beat_inc_d[IDX_W-1:0]];
                            cti_q  <= cti_for(inc_is_last_d);
                        end
                    end
                end

                ST_FIN: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // len_q already excludes the chunk in flight, so next_len_d / next_chunk_d are not needed
    // for sequencing; they stay as readable names for the remaining-work arithmetic.
    logic unused_next;
    assign unused_next = ^{next_len_d, next_chunk_d};

    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;

    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_sel_o = cyc_q ? 4'hF : 4'h0;
    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = stb_q;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_cti_o = cti_q;
    assign wb.wb_bte_o = 2'b00;

endmodule
